out_uart_tx: RTL and testbench
==============================

Name: out_uart_tx

Overview:
- Downstream consumer of the CPU top's byte output port: `out_dat[7:0]` plus `out_ctl`, where every toggle of `out_ctl` marks one new byte.
- Detects each toggle, buffers the byte in a small synchronous FIFO and serializes it as UART 8N1 on `tx`.
- Same clock domain as the CPU top; `clk` and `rst_n` are shared, so no synchronizer is needed.

Parameters:
- CLK_DIV, 434, clk cycles per UART bit (50 MHz / 115200); legal range >= 2.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- in_dat  input  8  byte from CPU output port (`out_dat`).
- in_ctl  input  1  toggle strobe from CPU output port (`out_ctl`).
- tx  output  1  UART serial line; idle high.
- busy  output  1  high while FIFO non-empty or a frame is in progress.
- overflow  output  1  sticky flag: a byte was dropped because the FIFO was full.
- level  output  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - tx=1, busy=0, overflow=0, level=0.
  - Internal ctl_q=0, matching the producer's reset value of `out_ctl`.
  - FSM in IDLE; bit counter and baud counter cleared.
- Toggle detect:
  - push = (in_ctl != ctl_q); ctl_q <= in_ctl every cycle.
  - On push, in_dat is written into the FIFO at that edge.
  - If in_ctl changes at edge E0, the push occurs at edge E1.
- FIFO:
  - Circular buffer with wrap-around read/write pointers, one bit wider than FIFO_AW.
  - level = wr_ptr - rd_ptr.
  - full when level == 2**FIFO_AW; empty when level == 0.
- Push while full:
  - Without a same-cycle pop: byte dropped, overflow <= 1, pointers unchanged.
  - With a same-cycle pop: push accepted and level unchanged. The pop is decided from the registered state, so there is no combinational path from push to pop.
- overflow is cleared only by reset.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO non-empty, pop into shift register and go to START; tx <= 0 at that same edge. A byte pushed at E1 therefore drives tx low from edge E2.
  - START: hold tx=0 for CLK_DIV cycles, then tx <= shift[0] and go to DATA.
  - DATA: each bit is held CLK_DIV cycles. Bits are sent LSB first. After bit 7 completes, tx <= 1 and go to STOP.
  - STOP: hold tx=1 for CLK_DIV cycles. At the end, if FIFO non-empty, pop directly and go to START (tx <= 0), so there is no idle gap between frames. Otherwise go to IDLE.
- Frame length: exactly 10*CLK_DIV cycles.
- Baud counter:
  - Counts 0..CLK_DIV-1 and restarts on every state entry.
  - Width is $clog2(CLK_DIV).
- tx is driven from a flop; it is glitch-free.
- busy = (state != IDLE) || (level != 0), registered or combinational from registers.
- Reset mid-frame: tx returns high immediately (asynchronous). FIFO contents and the partial frame are discarded; nothing is resent.
- in_dat is sampled only on push cycles; it is don't-care otherwise.

Decomposition:
- Shared package out_uart_pkg:
  - FSM state enum (IDLE/START/DATA/STOP, 2 bits).
  - UART_DATA_BITS=8.
  - Line level constants: UART_IDLE=1, UART_START=0.
- One natural sub-module: out_fifo (parameters DW=8, AW).
  - Ports: clk, rst_n, push, din, pop, dout, full, empty, level.
  - Overflow detection lives in out_fifo.
- Top-level out_uart_tx holds toggle detect, baud counter and FSM.
- Expected size about 200 lines total.

Test Plan:
- Single byte: CLK_DIV=4; toggle in_ctl with in_dat=0x55 at E0 -> tx low from E2 for 4 cycles; data 1,0,1,0,1,0,1,0 at 4 cycles each; stop high 4 cycles; busy falls after 40 cycles; level peaks at 1.
- Back-to-back: CLK_DIV=4; toggles on consecutive cycles with 0xA5, 0x3C, 0xFF -> three frames, 120 cycles with no idle gap between stop and next start; decoded bytes in order; overflow=0.
- Overflow: CLK_DIV=8, FIFO_AW=2; 7 toggles on consecutive cycles with 0x01..0x07 -> first pop at E2 frees one slot; bytes 0x01..0x05 transmitted, 0x06 and 0x07 dropped; overflow=1 and remains 1 after the FIFO drains.
- Full with simultaneous push/pop: fill FIFO to 4 entries, then toggle exactly at the STOP->START pop edge -> byte accepted; level stays 4; overflow stays 0.
- Reset mid-frame: assert rst_n low during DATA bit 3 of 0x81, with 2 bytes queued -> tx=1 immediately; level=0; busy=0; after release, no output until a new toggle.
- No toggle: hold in_ctl constant while in_dat changes randomly for 1000 cycles -> tx stays 1, busy=0, level=0.

Source files
------------

// File: rtl/out_uart_pkg.sv
// rtl/out_uart_pkg.sv - shared types and constants for the byte-port UART transmitter
package out_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE      = 1'b1;
    localparam logic UART_START     = 1'b0;

endpackage

// File: rtl/out_uart_tx_if.sv
// rtl/out_uart_tx_if.sv - CPU byte port in, UART line and status out
interface out_uart_tx_if #(
    parameter int FIFO_AW = 4
);
    logic [out_uart_pkg::UART_DATA_BITS-1:0] in_dat;
    logic                                    in_ctl;
    logic                                    tx;
    logic                                    busy;
    logic                                    overflow;
    logic [FIFO_AW:0]                        level;

    modport master (
        output in_dat, in_ctl,
        input  tx, busy, overflow, level
    );

    modport slave (
        input  in_dat, in_ctl,
        output tx, busy, overflow, level
    );
endinterface

// File: rtl/out_fifo.sv
// rtl/out_fifo.sv - circular byte FIFO with sticky overflow on dropped pushes
module out_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow
);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == DEPTH);
    assign empty   = (level == '0);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when a pop frees the slot at the same edge.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/out_uart_tx.sv
// rtl/out_uart_tx.sv - toggle-strobed byte capture, FIFO buffering and UART 8N1 serializer
module out_uart_tx
    import out_uart_pkg::*;
#(
    parameter int CLK_DIV = 434,
    parameter int FIFO_AW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    out_uart_tx_if.slave bus
);
    localparam int             CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [2:0]     BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_state_e                state;
    logic [CW-1:0]              baud;
    logic [2:0]                 bit_cnt;
    logic [UART_DATA_BITS-1:0]  shift;
    logic                       tx_q;
    logic                       ctl_q;
    logic                       push;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [UART_DATA_BITS-1:0]  fifo_dout;
    logic [FIFO_AW:0]           fifo_level;
    logic                       baud_end;

    assign push     = (bus.in_ctl != ctl_q);
    assign baud_end = (baud == BAUD_LAST);
    // Pop depends only on registered state, never on this cycle's push.
    assign fifo_pop = !fifo_empty && ((state == IDLE) || (state == STOP && baud_end));

    out_fifo #(.DW(UART_DATA_BITS), .AW(FIFO_AW)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .din      (bus.in_dat),
        .pop      (fifo_pop),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level),
        .overflow (bus.overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx_q    <= UART_IDLE;
            ctl_q   <= 1'b0;
        end else begin
            ctl_q <= bus.in_ctl;
            case (state)
                IDLE: begin
                    tx_q <= UART_IDLE;
                    if (fifo_pop) begin
                        shift <= fifo_dout;
                        tx_q  <= UART_START;
                        baud  <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        tx_q    <= shift[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            tx_q  <= UART_IDLE;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shift   <= shift >> 1;
                            tx_q    <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (fifo_pop) begin
                            shift <= fifo_dout;
                            tx_q  <= UART_START;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx    = tx_q;
    assign bus.busy  = (state != IDLE) || !fifo_empty;
    assign bus.level = fifo_level;

endmodule

// File: tb/tb_out_uart_tx.sv
// tb/tb_out_uart_tx.sv - scoreboard bench for out_uart_tx against a frame-timing model
module tb_out_uart_tx;
    localparam int CLK_DIV = 4;
    localparam int FIFO_AW = 2;
    localparam int DEPTH   = 4;
    localparam int FRAME   = 10 * CLK_DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    out_uart_tx_if #(.FIFO_AW(FIFO_AW)) bus ();

    out_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Reference model: byte queue plus remaining cycles of the frame on the line.
    logic [7:0] m_fifo[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_cur    = 8'h00;
    int         m_remain = 0;
    logic       m_ovf    = 1'b0;
    logic       m_ctl    = 1'b0;
    bit         pop_m, push_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_fifo.delete();
            exp_q.delete();
            m_remain = 0;
            m_ovf    = 1'b0;
            m_ctl    = 1'b0;
        end else begin
            pop_m  = (m_remain <= 1) && (m_fifo.size() > 0);
            push_m = (bus.in_ctl != m_ctl);
            m_ctl  = bus.in_ctl;
            if (pop_m) m_cur = m_fifo.pop_front();
            if (push_m) begin
                if (m_fifo.size() < DEPTH) begin
                    m_fifo.push_back(bus.in_dat);
                    exp_q.push_back(bus.in_dat);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (pop_m) m_remain = FRAME;
            else if (m_remain > 0) m_remain--;
        end
    end

    function automatic logic exp_tx();
        int slot;
        if (m_remain == 0) return 1'b1;
        slot = (FRAME - m_remain) / CLK_DIV;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_cur[slot-1];
        return 1'b1;
    endfunction

    // Cycle checks plus a line decoder that pops the scoreboard per received frame.
    bit         d_act  = 1'b0;
    int         d_off  = 0;
    logic [7:0] d_byte = 8'h00;

    always @(negedge clk) begin
        chk("tx", bus.tx, exp_tx());
        chk("busy", bus.busy, (m_remain > 0) || (m_fifo.size() > 0));
        chk("level", bus.level, m_fifo.size());
        chk("overflow", bus.overflow, m_ovf);
        if (!rst_n) begin
            d_act = 1'b0;
        end else begin
            if (!d_act && bus.tx == 1'b0) begin
                d_act = 1'b1;
                d_off = 0;
            end else if (d_act) begin
                d_off++;
            end
            if (d_act) begin
                if (d_off >= CLK_DIV + CLK_DIV/2 && d_off < 9*CLK_DIV &&
                    (d_off - CLK_DIV/2) % CLK_DIV == 0)
                    d_byte[(d_off - CLK_DIV/2)/CLK_DIV - 1] = bus.tx;
                if (d_off == 9*CLK_DIV + CLK_DIV/2) begin
                    chk("stop_bit", bus.tx, 1);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL rx_unexpected: got 0x%02h expected no frame", d_byte);
                    end else begin
                        chk("rx_byte", d_byte, exp_q.pop_front());
                    end
                end
                if (d_off == FRAME - 1) d_act = 1'b0;
            end
        end
    end

    task automatic toggle(input logic [7:0] d);
        @(negedge clk);
        bus.in_dat = d;
        bus.in_ctl = ~bus.in_ctl;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_dat = 8'($urandom);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while ((m_remain > 0 || m_fifo.size() > 0) && k < budget) begin
            @(negedge clk);
            bus.in_dat = 8'($urandom);
            k++;
        end
        if (k >= budget) fail_now(name);
        idle(2);
    endtask

    initial begin
        int k;
        bus.in_ctl = 1'b0;
        bus.in_dat = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_tx", bus.tx, 1);
        chk("reset_busy", bus.busy, 0);
        chk("reset_level", bus.level, 0);
        rst_n = 1'b1;
        idle(3);

        toggle(8'h55);
        wait_drain("single_drain", 200);

        toggle(8'hA5); toggle(8'h3C); toggle(8'hFF);
        wait_drain("b2b_drain", 400);
        chk("b2b_overflow", bus.overflow, 0);

        for (int i = 0; i < 5; i++) toggle(8'(8'h11 + i));
        k = 0;
        while (!(m_remain == 1 && m_fifo.size() == DEPTH) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) fail_now("full_wait");
        bus.in_dat = 8'h16;
        bus.in_ctl = ~bus.in_ctl;
        @(negedge clk);
        chk("full_pushpop_level", bus.level, DEPTH);
        chk("full_pushpop_overflow", bus.overflow, 0);
        wait_drain("full_drain", 600);

        for (int i = 1; i <= 7; i++) toggle(8'(i));
        @(negedge clk);
        chk("overflow_set", bus.overflow, 1);
        chk("overflow_level", bus.level, DEPTH);
        wait_drain("overflow_drain", 600);
        chk("overflow_sticky", bus.overflow, 1);

        toggle(8'h81); toggle(8'h42); toggle(8'h24);
        k = 0;
        while (m_remain != FRAME - 4*CLK_DIV - 1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) fail_now("reset_wait");
        #1 rst_n = 1'b0;
        bus.in_ctl = 1'b0;
        #1;
        chk("midreset_tx", bus.tx, 1);
        chk("midreset_level", bus.level, 0);
        chk("midreset_busy", bus.busy, 0);
        chk("midreset_overflow", bus.overflow, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(60);

        idle(1000);
        chk("quiet_tx", bus.tx, 1);
        chk("quiet_busy", bus.busy, 0);
        chk("quiet_level", bus.level, 0);

        repeat (80) begin
            if ($urandom_range(0, 3) != 0) toggle(8'($urandom));
            else idle($urandom_range(1, 30));
        end
        wait_drain("random_drain", 4000);
        chk("all_frames_seen", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
